// File: rtl/adder_pkg.sv
// Shared constants for the width-parameterised adder slice.
// No logic lives here; only the default operand width.
// Imported by the interface and the top.
package adder_pkg;

  // Default operand/sum width when the integrator does not override N.
  localparam int ADDER_W_DEFAULT = 3;

endpackage

// File: rtl/full_adder_using_parameter_if.sv
// Operand/result bundle for the registered N-bit adder.
// Latency is a property of the attached adder (one cycle), not of this bundle.
// No backpressure signal: a producer may present an operation every cycle.
interface full_adder_using_parameter_if
  import adder_pkg::*;
#(
  parameter int N = ADDER_W_DEFAULT
);

  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] sum;
  logic         carry;
  logic         out_valid;

  // Producer of operands, consumer of results.
  modport master (
    output in_valid, a, b, cin,
    input  sum, carry, out_valid
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, cin,
    output sum, carry, out_valid
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder: s = a^b^ci, co = generate | propagate&ci.
// Purely combinational, zero cycles.
// No flow control; it is a leaf of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry-out of a single bit position.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder_using_parameter.sv
// N-bit ripple-carry adder with carry-in/out and a valid flag, result registered.
// Latency 1 cycle: operands sampled at edge T are visible on sum/carry after T.
// No backpressure: accepts an operation every cycle; idle cycles hold the last result.
module full_adder_using_parameter
  import adder_pkg::*;
#(
  parameter int N = ADDER_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  full_adder_using_parameter_if.slave    bus
);

  // c[i] is the carry into bit i; c[0] is the external carry-in, c[N] the carry-out.
  logic [N:0]   c;
  logic [N-1:0] s;

  logic [N-1:0] sum_q;
  logic         carry_q;
  logic         vld_q;

  assign c[0] = bus.cin;

  // Ripple chain: one full-adder cell per bit, carry passed upward.
  // The whole chain sits between the input pins and the result flops, so
  // wide instances need their timing checked by whoever integrates them.
  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Result and valid registers; the result only loads on a qualified cycle so
  // garbage operands presented while idle never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= s;
        carry_q <= c[N];
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_using_parameter.sv
// Scoreboard bench for the registered adder at N=3, N=1 and N=16.
// Expected {carry,sum} values are queued when operations are issued and
// popped by a negedge monitor whenever out_valid is high.
module tb_full_adder_using_parameter;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  full_adder_using_parameter_if #(.N(3))  if3  ();
  full_adder_using_parameter_if #(.N(1))  if1  ();
  full_adder_using_parameter_if #(.N(16)) if16 ();

  full_adder_using_parameter #(.N(3))  u_dut3  (.clk(clk), .rst_n(rst_n), .bus(if3));
  full_adder_using_parameter #(.N(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder_using_parameter #(.N(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {carry,sum}, zero-extended to 17 bits.
  logic [16:0] q3[$];
  logic [16:0] q1[$];
  logic [16:0] q16[$];
  logic [16:0] last3, last1, last16;

  // Reference: the true integer sum of the operands; its value below 2^N is
  // the sum and anything at 2^N or above shows up as the carry bit.
  function automatic logic [16:0] ref_add(input int a, input int b, input int c);
    int t;
    t = a + b + c;
    return 17'(t);
  endfunction

  task automatic cmp(input string nm, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: out_valid high with no queued expectation at %0t", nm, $time);
  endtask

  // Monitor: results on out_valid, held values otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      q3.delete(); q1.delete(); q16.delete();
      last3 = '0; last1 = '0; last16 = '0;
    end else begin
      if (if3.out_valid) begin
        if (q3.size() == 0) unexpected("n3 result");
        else begin last3 = q3.pop_front(); cmp("n3 result", 17'({if3.carry, if3.sum}), last3); end
      end else cmp("n3 hold", 17'({if3.carry, if3.sum}), last3);
      if (if1.out_valid) begin
        if (q1.size() == 0) unexpected("n1 result");
        else begin last1 = q1.pop_front(); cmp("n1 result", 17'({if1.carry, if1.sum}), last1); end
      end else cmp("n1 hold", 17'({if1.carry, if1.sum}), last1);
      if (if16.out_valid) begin
        if (q16.size() == 0) unexpected("n16 result");
        else begin last16 = q16.pop_front(); cmp("n16 result", 17'({if16.carry, if16.sum}), last16); end
      end else cmp("n16 hold", 17'({if16.carry, if16.sum}), last16);
    end
  end

  // Drive N=3; e < 0 means take the expectation from the reference model.
  // With v=0 the given operands are still driven but nothing is queued.
  task automatic drv3(input bit v, input int a, input int b, input int c, input int e);
    if3.in_valid = v;
    if3.a        = 3'(a);
    if3.b        = 3'(b);
    if3.cin      = c[0];
    if (v) q3.push_back(e < 0 ? ref_add(a % 8, b % 8, c % 2) : 17'(e));
  endtask

  task automatic idle3();
    if3.in_valid = 1'b0;
    if3.a        = 'x;
    if3.b        = 'x;
    if3.cin      = 1'bx;
  endtask

  task automatic rnd1();
    int a, b, c;
    a = int'($urandom_range(0, 1));
    b = int'($urandom_range(0, 1));
    c = int'($urandom_range(0, 1));
    if ($urandom_range(0, 3) != 0) begin
      if1.in_valid = 1'b1; if1.a = 1'(a); if1.b = 1'(b); if1.cin = c[0];
      q1.push_back(ref_add(a, b, c));
    end else begin
      if1.in_valid = 1'b0; if1.a = 'x; if1.b = 'x; if1.cin = 1'bx;
    end
  endtask

  task automatic rnd16();
    int a, b, c;
    a = int'($urandom_range(0, 65535));
    b = int'($urandom_range(0, 65535));
    c = int'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) begin a = 65535; b = 65535; c = 1; end
    if ($urandom_range(0, 3) != 0) begin
      if16.in_valid = 1'b1; if16.a = 16'(a); if16.b = 16'(b); if16.cin = c[0];
      q16.push_back(ref_add(a, b, c));
    end else begin
      if16.in_valid = 1'b0; if16.a = 'x; if16.b = 'x; if16.cin = 1'bx;
    end
  endtask

  task automatic idle_wide();
    if1.in_valid  = 1'b0; if1.a  = 'x; if1.b  = 'x; if1.cin  = 1'bx;
    if16.in_valid = 1'b0; if16.a = 'x; if16.b = 'x; if16.cin = 1'bx;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle3();
    idle_wide();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic add, then wrap and maximum operands.
    cyc(); drv3(1, 1, 5, 0, 6);
    cyc(); drv3(1, 7, 1, 0, 8);
    cyc(); drv3(1, 7, 7, 1, 15);
    // Hold: load 110, then present operands without in_valid.
    cyc(); drv3(1, 1, 5, 0, 6);
    cyc(); drv3(0, 2, 2, 0, 0);
    cyc(); idle3();
    // Back-to-back stream.
    cyc(); drv3(1, 0, 0, 0, 0);
    cyc(); drv3(1, 3, 3, 1, 7);
    cyc(); drv3(1, 4, 4, 0, 8);
    cyc(); idle3();

    // Reset asserted mid-cycle with a loaded result and an operation pending.
    cyc(); drv3(1, 6, 6, 0, -1);
    cyc(); if3.in_valid = 1'b1; if3.a = 3'd5; if3.b = 3'd3; if3.cin = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    cmp("reset n3 async",  17'({if3.out_valid, if3.carry, if3.sum}), 17'd0);
    cmp("reset n1 async",  17'({if1.out_valid, if1.carry, if1.sum}), 17'd0);
    cmp("reset n16 async", 17'({if16.out_valid, if16.carry, if16.sum}), 17'd0);
    cyc(); idle3();
    #2 rst_n = 1'b1;
    // First edge after release samples normally.
    cyc(); drv3(1, 2, 3, 1, 6);
    cyc(); idle3();

    // Exhaustive N=3 alongside random N=1 and N=16 traffic.
    for (int i = 0; i < 128; i++) begin
      cyc();
      drv3(1, i / 16, (i / 2) % 8, i % 2, -1);
      rnd1();
      rnd16();
    end

    // Random N=3 with idle gaps carrying unknown operands.
    for (int i = 0; i < 80; i++) begin
      cyc();
      if ($urandom_range(0, 2) != 0)
        drv3(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), -1);
      else
        idle3();
      rnd1();
      rnd16();
    end

    cyc(); idle3(); idle_wide();
    repeat (3) @(negedge clk);
    cmp("n3 drained",  17'(q3.size()),  17'd0);
    cmp("n1 drained",  17'(q1.size()),  17'd0);
    cmp("n16 drained", 17'(q16.size()), 17'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
